// File: rtl/tlc_pkg.sv
// Shared traffic-light definitions: light-state encoding, sensor channel indices and default timing.
package tlc_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } tlc_state_e;

  localparam int unsigned CH_H   = 0;
  localparam int unsigned CH_C   = 1;
  localparam int unsigned NUM_CH = 2;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_STUCK_CYCLES    = 1000;
  localparam int unsigned DEF_CNT_W           = 16;
  localparam int unsigned DEF_T_GREEN_LONG    = 30;
  localparam int unsigned DEF_T_GREEN_SHORT   = 10;
  localparam int unsigned DEF_T_YELLOW        = 3;

endpackage

// File: rtl/tlc_sense_chan.sv
// One loop-detector channel: 2-flop sync, debounce, request latch, stuck detect.
// Optional saturating vehicle counter when TLC_SENSE_COUNT_EN is defined.
module tlc_sense_chan
  import tlc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES
`ifdef TLC_SENSE_COUNT_EN
  ,
  parameter int unsigned CNT_W           = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_i,
  input  logic             green_i,
  output logic             req_o,
  output logic             fault_o
`ifdef TLC_SENSE_COUNT_EN
  ,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned ST_W = $clog2(STUCK_CYCLES + 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            deb_q, deb_d;
  logic [DB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic            req_q, req_d;
  logic [ST_W-1:0] stuck_cnt_q, stuck_cnt_d;
  logic            fault_q, fault_d;
`ifdef TLC_SENSE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    sync1_d     = raw_i;
    sync2_d     = sync1_q;
    deb_d       = deb_q;
    deb_cnt_d   = '0;
    req_d       = req_q;
    stuck_cnt_d = stuck_cnt_q;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DB_W'(1);
      end
    end

    if (deb_q && !green_i) begin
      req_d = 1'b1;
    end else if (green_i && !deb_q) begin
      req_d = 1'b0;
    end

    // Stuck counter and fault drop on the same edge the debounced level falls.
    if (!deb_d) begin
      stuck_cnt_d = '0;
    end else if (deb_q && (stuck_cnt_q != ST_W'(STUCK_CYCLES))) begin
      stuck_cnt_d = stuck_cnt_q + ST_W'(1);
    end
    fault_d = deb_d && (stuck_cnt_d == ST_W'(STUCK_CYCLES));

`ifdef TLC_SENSE_COUNT_EN
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (deb_d && !deb_q && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_q       <= 1'b0;
      deb_cnt_q   <= '0;
      req_q       <= 1'b0;
      stuck_cnt_q <= '0;
      fault_q     <= 1'b0;
`ifdef TLC_SENSE_COUNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      req_q       <= req_d;
      stuck_cnt_q <= stuck_cnt_d;
      fault_q     <= fault_d;
`ifdef TLC_SENSE_COUNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_o   = req_q;
  assign fault_o = fault_q;
`ifdef TLC_SENSE_COUNT_EN
  assign cnt_o   = cnt_q;
`endif

endmodule

// File: rtl/tlc_sensor_conditioner.sv
// Conditions highway/country loop detectors into latched requests for the light controller.
// Define TLC_SENSE_COUNT_EN to add per-channel vehicle counters (clr_cnt, cnt_h, cnt_c).
module tlc_sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES
`ifdef TLC_SENSE_COUNT_EN
  ,
  parameter int unsigned CNT_W           = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_h,
  input  logic             raw_c,
  input  logic             gh_i,
  input  logic             gc_i,
  output logic             xh,
  output logic             xc,
  output logic             fault_h,
  output logic             fault_c
`ifdef TLC_SENSE_COUNT_EN
  ,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_h,
  output logic [CNT_W-1:0] cnt_c
`endif
);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] green;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] fault;

  assign raw[CH_H]   = raw_h;
  assign raw[CH_C]   = raw_c;
  assign green[CH_H] = gh_i;
  assign green[CH_C] = gc_i;

  tlc_sense_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
`ifdef TLC_SENSE_COUNT_EN
    ,
    .CNT_W           (CNT_W)
`endif
  ) u_chan_h (
    .clk       (clk),
    .reset     (reset),
    .raw_i     (raw[CH_H]),
    .green_i   (green[CH_H]),
    .req_o     (req[CH_H]),
    .fault_o   (fault[CH_H])
`ifdef TLC_SENSE_COUNT_EN
    ,
    .clr_cnt_i (clr_cnt),
    .cnt_o     (cnt_h)
`endif
  );

  tlc_sense_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
`ifdef TLC_SENSE_COUNT_EN
    ,
    .CNT_W           (CNT_W)
`endif
  ) u_chan_c (
    .clk       (clk),
    .reset     (reset),
    .raw_i     (raw[CH_C]),
    .green_i   (green[CH_C]),
    .req_o     (req[CH_C]),
    .fault_o   (fault[CH_C])
`ifdef TLC_SENSE_COUNT_EN
    ,
    .clr_cnt_i (clr_cnt),
    .cnt_o     (cnt_c)
`endif
  );

  // A stuck sensor is masked so it cannot starve the other approach.
  assign xh      = req[CH_H] & ~fault[CH_H];
  assign xc      = req[CH_C] & ~fault[CH_C];
  assign fault_h = fault[CH_H];
  assign fault_c = fault[CH_C];

endmodule

// File: tb/tb_tlc_sensor_conditioner.sv
// Directed self-checking bench for tlc_sensor_conditioner (DEBOUNCE_CYCLES=4, STUCK_CYCLES=20).
module tb_tlc_sensor_conditioner;

  logic clk = 1'b0;
  logic reset, raw_h, raw_c, gh_i, gc_i;
  logic xh, xc, fault_h, fault_c;
`ifdef TLC_SENSE_COUNT_EN
  logic       clr_cnt;
  logic [1:0] cnt_h, cnt_c;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

`ifdef TLC_SENSE_COUNT_EN
  tlc_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .STUCK_CYCLES(20), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .raw_h(raw_h), .raw_c(raw_c), .gh_i(gh_i), .gc_i(gc_i),
    .xh(xh), .xc(xc), .fault_h(fault_h), .fault_c(fault_c),
    .clr_cnt(clr_cnt), .cnt_h(cnt_h), .cnt_c(cnt_c));
`else
  tlc_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .STUCK_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .raw_h(raw_h), .raw_c(raw_c), .gh_i(gh_i), .gc_i(gc_i),
    .xh(xh), .xc(xc), .fault_h(fault_h), .fault_c(fault_c));
`endif

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; raw_h = 1'b1; raw_c = 1'b1; gh_i = 1'b0; gc_i = 1'b0;
`ifdef TLC_SENSE_COUNT_EN
    clr_cnt = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if ({xh, xc, fault_h, fault_c} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b want 0000", i, {xh, xc, fault_h, fault_c});
      end
    end
    reset = 1'b0; raw_h = 1'b0; raw_c = 1'b0;
    tick(10);
    checks++;
    if ({xh, xc, fault_h, fault_c} !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle: got %b want 0000", {xh, xc, fault_h, fault_c});
    end
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    raw_c = 1'b1;
    tick(3);
    raw_c = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      seen = seen | xc;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL glitch_rejected: xc seen=%b want 0", seen);
    end
  endtask

  task automatic test_latch();
    logic dropped;
    dropped = 1'b0;
    raw_c = 1'b1;
    tick(6);
    checks++;
    if (xc !== 1'b0) begin
      errors++;
      $display("FAIL latch_early: xc=%b want 0 at 6 cycles", xc);
    end
    tick(1);
    checks++;
    if (xc !== 1'b1) begin
      errors++;
      $display("FAIL latch_rise: xc=%b want 1 at 7 cycles", xc);
    end
    raw_c = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (xc !== 1'b1) dropped = 1'b1;
    end
    checks++;
    if (dropped !== 1'b0) begin
      errors++;
      $display("FAIL latch_hold: xc dropped=%b want 0", dropped);
    end
    gc_i = 1'b1;
    tick(1);
    checks++;
    if (xc !== 1'b0) begin
      errors++;
      $display("FAIL latch_served: xc=%b want 0", xc);
    end
    gc_i = 1'b0;
    tick(2);
    checks++;
    if ({xc, xh} !== 2'b00) begin
      errors++;
      $display("FAIL latch_idle: {xc,xh}=%b want 00", {xc, xh});
    end
  endtask

  task automatic test_green_hold();
    gh_i = 1'b1; raw_h = 1'b1;
    tick(12);
    checks++;
    if (xh !== 1'b0) begin
      errors++;
      $display("FAIL green_hold: xh=%b want 0", xh);
    end
    gh_i = 1'b0;
    tick(1);
    checks++;
    if (xh !== 1'b1) begin
      errors++;
      $display("FAIL green_drop: xh=%b want 1", xh);
    end
    raw_h = 1'b0;
    tick(8);
    gh_i = 1'b1;
    tick(1);
    checks++;
    if (xh !== 1'b0) begin
      errors++;
      $display("FAIL green_clear: xh=%b want 0", xh);
    end
    gh_i = 1'b0;
    tick(2);
  endtask

  task automatic test_stuck();
    raw_h = 1'b1;
    tick(25);
    checks++;
    if ({fault_h, xh} !== 2'b01) begin
      errors++;
      $display("FAIL stuck_before: {fault_h,xh}=%b want 01", {fault_h, xh});
    end
    tick(1);
    checks++;
    if ({fault_h, xh} !== 2'b10) begin
      errors++;
      $display("FAIL stuck_set: {fault_h,xh}=%b want 10", {fault_h, xh});
    end
    tick(10);
    checks++;
    if ({fault_h, xh, fault_c, xc} !== 4'b1000) begin
      errors++;
      $display("FAIL stuck_hold: {fault_h,xh,fault_c,xc}=%b want 1000", {fault_h, xh, fault_c, xc});
    end
    raw_h = 1'b0;
    tick(5);
    checks++;
    if (fault_h !== 1'b1) begin
      errors++;
      $display("FAIL stuck_release_early: fault_h=%b want 1", fault_h);
    end
    tick(1);
    checks++;
    if ({fault_h, xh} !== 2'b01) begin
      errors++;
      $display("FAIL stuck_release: {fault_h,xh}=%b want 01", {fault_h, xh});
    end
    gh_i = 1'b1;
    tick(1);
    gh_i = 1'b0;
    checks++;
    if (xh !== 1'b0) begin
      errors++;
      $display("FAIL stuck_served: xh=%b want 0", xh);
    end
    tick(2);
  endtask

  task automatic test_back_to_back();
    raw_h = 1'b1; raw_c = 1'b1;
    tick(6);
    checks++;
    if ({xh, xc} !== 2'b00) begin
      errors++;
      $display("FAIL both_early: {xh,xc}=%b want 00", {xh, xc});
    end
    tick(1);
    checks++;
    if ({xh, xc} !== 2'b11) begin
      errors++;
      $display("FAIL both_rise: {xh,xc}=%b want 11", {xh, xc});
    end
    raw_h = 1'b0; raw_c = 1'b0;
    tick(8);
    gh_i = 1'b1;
    tick(1);
    checks++;
    if ({xh, xc} !== 2'b01) begin
      errors++;
      $display("FAIL both_serve_h: {xh,xc}=%b want 01", {xh, xc});
    end
    gh_i = 1'b0; gc_i = 1'b1;
    tick(1);
    gc_i = 1'b0;
    checks++;
    if ({xh, xc} !== 2'b00) begin
      errors++;
      $display("FAIL both_serve_c: {xh,xc}=%b want 00", {xh, xc});
    end
    tick(2);
  endtask

`ifdef TLC_SENSE_COUNT_EN
  task automatic test_count();
    for (int p = 0; p < 5; p++) begin
      raw_c = 1'b1;
      tick(6);
      raw_c = 1'b0;
      tick(8);
    end
    checks++;
    if ({cnt_c, cnt_h} !== 4'b1100) begin
      errors++;
      $display("FAIL count_saturate: cnt_c=%0d cnt_h=%0d want 3,0", cnt_c, cnt_h);
    end
    raw_c = 1'b1;
    tick(5);
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    checks++;
    if (cnt_c !== 2'd0) begin
      errors++;
      $display("FAIL count_clear_wins: cnt_c=%0d want 0", cnt_c);
    end
    tick(20);
    checks++;
    if ({fault_c, xc, cnt_c} !== 4'b1000) begin
      errors++;
      $display("FAIL count_fault: {fault_c,xc,cnt_c}=%b want 1000", {fault_c, xc, cnt_c});
    end
    raw_h = 1'b1;
    tick(7);
    checks++;
    if ({xh, cnt_h} !== 3'b101) begin
      errors++;
      $display("FAIL count_h: {xh,cnt_h}=%b want 101", {xh, cnt_h});
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if ({xh, xc, fault_c, cnt_c, cnt_h} !== 7'b0) begin
      errors++;
      $display("FAIL count_reset: {xh,xc,fault_c,cnt_c,cnt_h}=%b want 0", {xh, xc, fault_c, cnt_c, cnt_h});
    end
    reset = 1'b0; raw_c = 1'b0; raw_h = 1'b0;
    tick(2);
  endtask
`endif

  task automatic test_mid_reset();
    raw_c = 1'b1;
    tick(30);
    reset = 1'b1;
    tick(1);
    checks++;
    if ({xc, fault_c} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: {xc,fault_c}=%b want 00", {xc, fault_c});
    end
    reset = 1'b0;
    raw_c = 1'b0;
    tick(12);
    checks++;
    if ({xc, fault_c} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_after: {xc,fault_c}=%b want 00", {xc, fault_c});
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_latch();
    test_green_hold();
    test_stuck();
    test_back_to_back();
`ifdef TLC_SENSE_COUNT_EN
    test_count();
`endif
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
